// File: rtl/ps2_host_port_if.sv
// Host-side register interface of the PS/2 port: a transmit request goes in;
// the received byte and the ready/error status pulses come out.
interface ps2_host_port_if;
    logic [7:0] i_data;
    logic       i_we;
    logic [7:0] o_data;
    logic       o_ready;
    logic       o_error;

    modport master (
        output i_data,
        output i_we,
        input  o_data,
        input  o_ready,
        input  o_error
    );

    modport slave (
        input  i_data,
        input  i_we,
        output o_data,
        output o_ready,
        output o_error
    );
endinterface

// File: rtl/ps2_host_port.sv
// PS/2 host port. It deserialises device-to-host frames and serialises
// host-to-device command bytes on the open-collector clock and data lines.
// The lines are only ever driven low or released.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | lines released; waits for a start bit or a transmit request
// RX        | shifts in 8 data bits, the parity bit and the stop bit
// INHIBIT   | host holds ps2clk low before a transmit
// TX        | device clocks; host presents bits, then samples the ACK
// WAIT_IDLE | after the ACK, waits for both lines to return high
module ps2_host_port #(
    parameter int unsigned I_CLK_FRQ  = 100_000_000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned RX_TO_US   = 2000,
    parameter int unsigned TX_TO_US   = 20000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    inout  wire            ps2clk,
    inout  wire            ps2data,
    ps2_host_port_if.slave bus
);

    localparam longint unsigned INHIBIT_L = (64'(I_CLK_FRQ) * 64'(INHIBIT_US)) / 64'd1_000_000;
    localparam longint unsigned RX_TO_L   = (64'(I_CLK_FRQ) * 64'(RX_TO_US)) / 64'd1_000_000;
    localparam longint unsigned TX_TO_L   = (64'(I_CLK_FRQ) * 64'(TX_TO_US)) / 64'd1_000_000;
    localparam longint unsigned MAX_L     = (TX_TO_L > RX_TO_L) ? TX_TO_L : RX_TO_L;

    // Each width is large enough to hold the count itself, even when that
    // count is an exact power of two.
    localparam int TIMER_W = $clog2(MAX_L + 1);
    localparam int INH_W   = $clog2(INHIBIT_L + 1);

    // Loading N-1 makes the terminal count fall N cycles after the load.
    localparam logic [TIMER_W-1:0] RX_TO_LOAD  = TIMER_W'(RX_TO_L - 1);
    localparam logic [TIMER_W-1:0] TX_TO_LOAD  = TIMER_W'(TX_TO_L - 1);
    localparam logic [INH_W-1:0]   INH_LOAD    = INH_W'(INHIBIT_L - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_INHIBIT,
        S_TX,
        S_WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           rx_sh_q, rx_sh_d;
    logic                 rx_par_q, rx_par_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic [7:0]           o_data_q, o_data_d;
    logic                 o_ready_q, o_ready_d;
    logic                 o_error_q, o_error_d;
    logic                 clk_drv_q, clk_drv_d;
    logic                 dat_drv_q, dat_drv_d;

    logic                 clk_meta_q, clk_sync_q, clk_prev_q;
    logic                 dat_meta_q, dat_sync_q;
    logic                 fall;

    logic [TIMER_W-1:0]   tmr_cnt_q;
    logic                 tmr_run_q;
    logic                 tmr_start;
    logic [TIMER_W-1:0]   tmr_load;
    logic                 tmr_done;

    logic [INH_W-1:0]     inh_cnt_q;
    logic                 inh_load;

    logic                 rx_ok;
    logic                 tx_par;

    assign ps2clk  = clk_drv_q ? 1'b0 : 1'bz;
    assign ps2data = dat_drv_q ? 1'b0 : 1'bz;

    assign bus.o_data  = o_data_q;
    assign bus.o_ready = o_ready_q;
    assign bus.o_error = o_error_q;

    assign fall     = clk_prev_q & ~clk_sync_q;
    assign tmr_done = tmr_run_q & (tmr_cnt_q == '0);
    // The stop bit is the current synced data level when the last edge is seen.
    assign rx_ok    = dat_sync_q & (^{rx_par_q, rx_sh_q});
    assign tx_par   = ~^tx_byte_q;

    // Two-flop synchronisers; the extra clock stage gives the falling-edge detector.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2clk;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2data;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Timeout down-counter: a load clears done, and done holds at zero until the next load.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmr_cnt_q <= '0;
            tmr_run_q <= 1'b0;
        end else if (tmr_start) begin
            tmr_cnt_q <= tmr_load;
            tmr_run_q <= 1'b1;
        end else if (tmr_cnt_q != '0) begin
            tmr_cnt_q <= tmr_cnt_q - TIMER_W'(1);
        end
    end

    // Clock-inhibit down-counter; its terminal count ends the INHIBIT phase.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inh_cnt_q <= '0;
        end else if (inh_load) begin
            inh_cnt_q <= INH_LOAD;
        end else if (inh_cnt_q != '0) begin
            inh_cnt_q <= inh_cnt_q - INH_W'(1);
        end
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            rx_sh_q   <= '0;
            rx_par_q  <= 1'b0;
            tx_byte_q <= '0;
            o_data_q  <= '0;
            o_ready_q <= 1'b0;
            o_error_q <= 1'b0;
            clk_drv_q <= 1'b0;
            dat_drv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_sh_q   <= rx_sh_d;
            rx_par_q  <= rx_par_d;
            tx_byte_q <= tx_byte_d;
            o_data_q  <= o_data_d;
            o_ready_q <= o_ready_d;
            o_error_q <= o_error_d;
            clk_drv_q <= clk_drv_d;
            dat_drv_q <= dat_drv_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_sh_d   = rx_sh_q;
        rx_par_d  = rx_par_q;
        tx_byte_d = tx_byte_q;
        o_data_d  = o_data_q;
        o_ready_d = 1'b0;
        o_error_d = 1'b0;
        clk_drv_d = clk_drv_q;
        dat_drv_d = dat_drv_q;
        tmr_start = 1'b0;
        tmr_load  = '0;
        inh_load  = 1'b0;

        // A transmit request silently abandons any reception in progress.
        // The transmit timeout covers the whole transaction, starting at the request.
        if ((state_q == S_IDLE || state_q == S_RX) && bus.i_we) begin
            tx_byte_d = bus.i_data;
            clk_drv_d = 1'b1;
            dat_drv_d = 1'b0;
            inh_load  = 1'b1;
            tmr_start = 1'b1;
            tmr_load  = TX_TO_LOAD;
            state_d   = S_INHIBIT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    clk_drv_d = 1'b0;
                    dat_drv_d = 1'b0;
                    if (fall) begin
                        if (!dat_sync_q) begin
                            bit_cnt_d = '0;
                            tmr_start = 1'b1;
                            tmr_load  = RX_TO_LOAD;
                            state_d   = S_RX;
                        end else begin
                            o_error_d = 1'b1;
                        end
                    end
                end

                S_RX: begin
                    if (tmr_done) begin
                        o_error_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (fall) begin
                        tmr_start = 1'b1;
                        tmr_load  = RX_TO_LOAD;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            rx_sh_d = {dat_sync_q, rx_sh_q[7:1]};
                        end else if (bit_cnt_q == 4'd8) begin
                            rx_par_d = dat_sync_q;
                        end else begin
                            state_d = S_IDLE;
                            if (rx_ok) begin
                                o_data_d  = rx_sh_q;
                                o_ready_d = 1'b1;
                            end else begin
                                o_error_d = 1'b1;
                            end
                        end
                    end
                end

                S_INHIBIT: begin
                    clk_drv_d = 1'b1;
                    if (tmr_done) begin
                        clk_drv_d = 1'b0;
                        dat_drv_d = 1'b0;
                        o_error_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (inh_cnt_q == '0) begin
                        clk_drv_d = 1'b0;
                        dat_drv_d = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = S_TX;
                    end
                end

                S_TX: begin
                    if (tmr_done) begin
                        clk_drv_d = 1'b0;
                        dat_drv_d = 1'b0;
                        o_error_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (fall) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            dat_drv_d = ~tx_byte_q[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == 4'd8) begin
                            dat_drv_d = ~tx_par;
                        end else if (bit_cnt_q == 4'd9) begin
                            dat_drv_d = 1'b0;
                        end else begin
                            if (!dat_sync_q) begin
                                state_d = S_WAIT_IDLE;
                            end else begin
                                o_error_d = 1'b1;
                                state_d   = S_IDLE;
                            end
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    if (tmr_done) begin
                        clk_drv_d = 1'b0;
                        dat_drv_d = 1'b0;
                        o_error_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (clk_sync_q && dat_sync_q) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    clk_drv_d = 1'b0;
                    dat_drv_d = 1'b0;
                    state_d   = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_port.sv
// Directed bench for ps2_host_port. A behavioural PS/2 device drives the
// open-collector lines, and a pull-up on each line stands in for the bus resistor.
// The clock is scaled to 1 MHz, so one cycle is 1 us.
module tb_ps2_host_port;

    localparam int unsigned CLK_FRQ     = 1_000_000;
    localparam int          INHIBIT_CYC = 100;
    localparam int          RX_TO_CYC   = 2000;
    localparam int          TX_TO_CYC   = 20000;
    localparam int          HALF_BIT    = 20;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    wire  ps2clk;
    wire  ps2data;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    assign ps2clk  = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2data = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2clk);
    pullup (ps2data);

    ps2_host_port_if bus ();

    ps2_host_port #(
        .I_CLK_FRQ (CLK_FRQ),
        .INHIBIT_US(100),
        .RX_TO_US  (2000),
        .TX_TO_US  (20000)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .ps2clk (ps2clk),
        .ps2data(ps2data),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    int   tests_run = 0;
    int   fails     = 0;
    int   ready_cnt = 0;
    int   err_cnt   = 0;
    logic both_high = 1'b0;

    // Pulse counters, sampled on the inactive clock edge.
    always @(negedge i_clk) begin
        if (bus.o_ready) ready_cnt++;
        if (bus.o_error) err_cnt++;
        if (bus.o_ready && bus.o_error) both_high = 1'b1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Device-to-host frame; nbits < 11 truncates the frame after that many clocks.
    task automatic dev_send(input logic [7:0] b, input logic par, input logic stop, input int nbits);
        logic [10:0] fr;
        fr = {stop, par, b, 1'b0};
        for (int k = 0; k < nbits; k++) begin
            dev_dat_low = ~fr[k];
            wait_cycles(HALF_BIT);
            dev_clk_low = 1'b1;
            wait_cycles(HALF_BIT);
            dev_clk_low = 1'b0;
        end
        dev_dat_low = 1'b0;
    endtask

    // Host-to-device: wait for the request-to-send, then clock nedges edges and
    // sample data late in each low phase. Edge 11 carries the ACK if ack=1.
    task automatic dev_receive(input int nedges, input logic ack, output logic [10:0] got, output logic ok);
        int w;
        got = '0;
        w   = 0;
        while (!(ps2clk === 1'b1 && ps2data === 1'b0) && w < INHIBIT_CYC + 50) begin
            w++;
            @(negedge i_clk);
        end
        ok = (w < INHIBIT_CYC + 50);
        if (ok) begin
            for (int k = 1; k <= nedges; k++) begin
                if (k == 11 && ack) dev_dat_low = 1'b1;
                wait_cycles(HALF_BIT);
                dev_clk_low = 1'b1;
                wait_cycles(HALF_BIT);
                got[k-1] = ps2data;
                dev_clk_low = 1'b0;
            end
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        wait_cycles(4);
        tests_run++;
        if (bus.o_data !== 8'h00 || bus.o_ready !== 1'b0 || bus.o_error !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: data=%h ready=%b error=%b, want 00/0/0", bus.o_data, bus.o_ready, bus.o_error);
        end
        tests_run++;
        if (ps2clk !== 1'b1 || ps2data !== 1'b1) begin
            fails++;
            $display("FAIL reset_lines: clk=%b data=%b, want released 1/1", ps2clk, ps2data);
        end
        i_rst = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_rx_good();
        int r0, e0;
        r0 = ready_cnt;
        e0 = err_cnt;
        dev_send(8'hAA, 1'b1, 1'b1, 11);
        wait_cycles(5);
        tests_run++;
        if (ready_cnt !== r0 + 1) begin
            fails++;
            $display("FAIL rx_aa_ready: got %0d pulses, want 1", ready_cnt - r0);
        end
        tests_run++;
        if (bus.o_data !== 8'hAA) begin
            fails++;
            $display("FAIL rx_aa_data: got %h, want aa", bus.o_data);
        end
        tests_run++;
        if (err_cnt !== e0) begin
            fails++;
            $display("FAIL rx_aa_noerr: got %0d error pulses, want 0", err_cnt - e0);
        end
    endtask

    task automatic test_rx_errors();
        int r0, e0;
        r0 = ready_cnt;
        e0 = err_cnt;
        dev_send(8'hFA, 1'b0, 1'b1, 11);
        wait_cycles(5);
        tests_run++;
        if (err_cnt !== e0 + 1 || ready_cnt !== r0) begin
            fails++;
            $display("FAIL rx_parity: errors=%0d ready=%0d, want 1/0", err_cnt - e0, ready_cnt - r0);
        end
        tests_run++;
        if (bus.o_data !== 8'hAA) begin
            fails++;
            $display("FAIL rx_parity_data: got %h, want aa (unchanged)", bus.o_data);
        end
        // Falling edge with data high is not a start bit.
        e0 = err_cnt;
        dev_dat_low = 1'b0;
        wait_cycles(HALF_BIT);
        dev_clk_low = 1'b1;
        wait_cycles(HALF_BIT);
        dev_clk_low = 1'b0;
        wait_cycles(5);
        tests_run++;
        if (err_cnt !== e0 + 1 || ready_cnt !== r0) begin
            fails++;
            $display("FAIL rx_bad_start: errors=%0d ready=%0d, want 1/0", err_cnt - e0, ready_cnt - r0);
        end
    endtask

    task automatic test_tx_ack();
        int          low, r0, e0;
        logic [10:0] got;
        logic        ok;
        e0 = err_cnt;
        bus.i_data = 8'hFF;
        bus.i_we   = 1'b1;
        @(negedge i_clk);
        bus.i_we   = 1'b0;
        low = 0;
        while (ps2clk === 1'b0 && low < INHIBIT_CYC + 20) begin
            low++;
            @(negedge i_clk);
        end
        tests_run++;
        if (low !== INHIBIT_CYC) begin
            fails++;
            $display("FAIL tx_inhibit_len: clk low %0d cycles, want %0d", low, INHIBIT_CYC);
        end
        tests_run++;
        if (ps2clk !== 1'b1 || ps2data !== 1'b0) begin
            fails++;
            $display("FAIL tx_rts: clk=%b data=%b, want 1/0", ps2clk, ps2data);
        end
        dev_receive(11, 1'b1, got, ok);
        tests_run++;
        if (ok !== 1'b1 || got[9:0] !== 10'b11_1111_1111) begin
            fails++;
            $display("FAIL tx_ff_bits: ok=%b stop,par,data=%b, want 1 / 1111111111", ok, got[9:0]);
        end
        wait_cycles(10);
        tests_run++;
        if (err_cnt !== e0 || ps2clk !== 1'b1 || ps2data !== 1'b1) begin
            fails++;
            $display("FAIL tx_ack_done: errors=%0d clk=%b data=%b, want 0/1/1", err_cnt - e0, ps2clk, ps2data);
        end
        r0 = ready_cnt;
        dev_send(8'hFA, 1'b1, 1'b1, 11);
        wait_cycles(5);
        tests_run++;
        if (ready_cnt !== r0 + 1 || bus.o_data !== 8'hFA) begin
            fails++;
            $display("FAIL rx_fa_after_tx: ready=%0d data=%h, want 1/fa", ready_cnt - r0, bus.o_data);
        end
    endtask

    task automatic test_tx_noack();
        int          e0, r0;
        logic [10:0] got;
        logic        ok;
        e0 = err_cnt;
        r0 = ready_cnt;
        bus.i_data = 8'h55;
        bus.i_we   = 1'b1;
        @(negedge i_clk);
        bus.i_we   = 1'b0;
        dev_receive(11, 1'b0, got, ok);
        tests_run++;
        if (ok !== 1'b1 || got[9:0] !== 10'b11_0101_0101) begin
            fails++;
            $display("FAIL tx_55_bits: ok=%b stop,par,data=%b, want 1 / 1101010101", ok, got[9:0]);
        end
        wait_cycles(5);
        tests_run++;
        if (err_cnt !== e0 + 1 || ready_cnt !== r0) begin
            fails++;
            $display("FAIL tx_noack_err: errors=%0d ready=%0d, want 1/0", err_cnt - e0, ready_cnt - r0);
        end
        tests_run++;
        if (ps2clk !== 1'b1 || ps2data !== 1'b1) begin
            fails++;
            $display("FAIL tx_noack_lines: clk=%b data=%b, want 1/1", ps2clk, ps2data);
        end
    endtask

    task automatic test_timeouts();
        int n, e0, r0;
        logic [7:0] d0;
        e0 = err_cnt;
        bus.i_data = 8'hF4;
        bus.i_we   = 1'b1;
        @(negedge i_clk);
        bus.i_we   = 1'b0;
        n = 0;
        while (bus.o_error !== 1'b1 && n < TX_TO_CYC + 10) begin
            n++;
            @(negedge i_clk);
        end
        tests_run++;
        if (n < TX_TO_CYC - 1 || n > TX_TO_CYC + 1) begin
            fails++;
            $display("FAIL tx_timeout: error after %0d cycles, want %0d +/-1", n, TX_TO_CYC);
        end
        wait_cycles(5);
        tests_run++;
        if (err_cnt !== e0 + 1 || ps2clk !== 1'b1 || ps2data !== 1'b1) begin
            fails++;
            $display("FAIL tx_timeout_lines: errors=%0d clk=%b data=%b, want 1/1/1", err_cnt - e0, ps2clk, ps2data);
        end
        // Start bit plus four data bits, then silence. The timeout is measured
        // from the last bus edge, and up to 5 cycles of sync/edge latency are allowed.
        e0 = err_cnt;
        r0 = ready_cnt;
        d0 = bus.o_data;
        dev_send(8'h0F, 1'b1, 1'b1, 5);
        n = 0;
        while (bus.o_error !== 1'b1 && n < RX_TO_CYC + 10) begin
            n++;
            @(negedge i_clk);
        end
        tests_run++;
        if (n + HALF_BIT < RX_TO_CYC || n + HALF_BIT > RX_TO_CYC + 5) begin
            fails++;
            $display("FAIL rx_timeout: error %0d cycles after last edge, want %0d..%0d", n + HALF_BIT, RX_TO_CYC, RX_TO_CYC + 5);
        end
        wait_cycles(5);
        tests_run++;
        if (err_cnt !== e0 + 1 || ready_cnt !== r0 || bus.o_data !== d0) begin
            fails++;
            $display("FAIL rx_timeout_state: errors=%0d ready=%0d data=%h, want 1/0/%h", err_cnt - e0, ready_cnt - r0, bus.o_data, d0);
        end
    endtask

    task automatic test_reset_mid_tx();
        int          r0, e0;
        logic [10:0] got;
        logic        ok;
        r0 = ready_cnt;
        e0 = err_cnt;
        bus.i_data = 8'h00;
        bus.i_we   = 1'b1;
        @(negedge i_clk);
        bus.i_we   = 1'b0;
        dev_receive(5, 1'b0, got, ok);
        tests_run++;
        if (ok !== 1'b1 || ps2data !== 1'b0) begin
            fails++;
            $display("FAIL mid_tx_bit4: ok=%b data=%b, want 1/0 (host driving)", ok, ps2data);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        tests_run++;
        if (ps2clk !== 1'b1 || ps2data !== 1'b1) begin
            fails++;
            $display("FAIL mid_tx_reset_lines: clk=%b data=%b, want 1/1", ps2clk, ps2data);
        end
        wait_cycles(5);
        tests_run++;
        if (ready_cnt !== r0 || err_cnt !== e0 || bus.o_data !== 8'h00) begin
            fails++;
            $display("FAIL mid_tx_reset_pulses: ready=%0d errors=%0d data=%h, want 0/0/00", ready_cnt - r0, err_cnt - e0, bus.o_data);
        end
        dev_send(8'h00, 1'b1, 1'b1, 11);
        wait_cycles(5);
        tests_run++;
        if (ready_cnt !== r0 + 1 || err_cnt !== e0 || bus.o_data !== 8'h00) begin
            fails++;
            $display("FAIL rx_00_after_reset: ready=%0d errors=%0d data=%h, want 1/0/00", ready_cnt - r0, err_cnt - e0, bus.o_data);
        end
    endtask

    task automatic test_exclusive_pulses();
        tests_run++;
        if (both_high !== 1'b0) begin
            fails++;
            $display("FAIL ready_error_overlap: seen=%b, want 0", both_high);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_data = 8'h00;
        bus.i_we   = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_rx_good();
        test_rx_errors();
        test_tx_ack();
        test_tx_noack();
        test_timeouts();
        test_reset_mid_tx();
        test_exclusive_pulses();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
